mem_loader: RTL and testbench
=============================

// Module: mem_loader
// PURPOSE
//  Upstream stage of the max-finder datapath. Accepts a valid/ready word stream,
//  writes it into the shared data memory at addresses 0..n-1, and latches the last
//  written address for the max-finder's addr_eq_last compare. Then pulses mf_start,
//  waits for mf_done and returns to idle. Owns the memory write port during loading.
// PARAMETERS
//  DW     8    data word width (bits)
//  AW     4    memory address width
//  DEPTH  16   memory words; legal range 1..2**AW
// PORTS
//  clk          in   1     rising-edge clock
//  reset_n      in   1     asynchronous, active-low reset
//  start        in   1     load request; sampled in IDLE only
//  in_valid     in   1     stream word valid
//  in_ready     out  1     stream ready
//  in_data      in   DW    stream word
//  in_last      in   1     final word of block
//  mem_we       out  1     memory write enable
//  mem_addr     out  AW    memory write address
//  mem_wdata    out  DW    memory write data
//  last_addr    out  AW    address of last word written (held until next load)
//  word_count   out  AW+1  words written in current/last block
//  mf_start     out  1     one-cycle pulse: max-finder may begin
//  mf_done      in   1     max-finder finished (level or pulse)
//  busy         out  1     high in every state except IDLE
//  err_overflow out  1     sticky: DEPTH reached without in_last
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, wr_ptr=0, last_addr=0, word_count=0,
//   err_overflow=0; all outputs 0.
//  Reset mid-load or mid-wait aborts immediately. Partial memory contents are
//   don't-care. No mf_start is issued.
//  States: IDLE, LOAD, HANDOFF, WAIT_MF.
//  IDLE: in_ready=0. start=1 -> LOAD; wr_ptr<=0, word_count<=0, err_overflow<=0.
//  LOAD: in_ready=1. accept = in_valid & in_ready.
//   mem_we=accept, mem_addr=wr_ptr, mem_wdata=in_data (combinational; write in same cycle).
//   On accept: wr_ptr<=wr_ptr+1, word_count<=word_count+1.
//   If accept & (in_last | wr_ptr==DEPTH-1): last_addr<=wr_ptr; ->HANDOFF.
//   If that accept has wr_ptr==DEPTH-1 and in_last=0: err_overflow<=1.
//   in_valid=0 stalls indefinitely; no timeout.
//  HANDOFF: mf_start=1 for exactly this cycle; in_ready=0; ->WAIT_MF.
//  WAIT_MF: in_ready=0. mf_done=1 -> IDLE. mf_done is ignored in all other states.
//  start outside IDLE is ignored. start and mf_done in the same cycle in WAIT_MF
//   -> IDLE only; that start is not honoured.
//  Minimum block is 1 word: in_last on first accept -> last_addr=0, word_count=1.
//  wr_ptr never wraps: HANDOFF is forced at DEPTH-1.
//  mem_addr=0 and mem_wdata=0 whenever mem_we=0.
//  Latency: last accept at cycle t -> mf_start at t+1.
// TESTING
//  T1: start, 5 words 3,9,1,7,2 (in_last on 2), in_valid always 1
//   -> mem[0..4]=3,9,1,7,2; last_addr=4; word_count=5; mf_start 1 cycle after the 2.
//  T2: single word 0xA5 with in_last
//   -> mem[0]=A5, last_addr=0, word_count=1, err_overflow=0, mf_start pulse.
//  T3: 16 words, DEPTH=16, in_last never set
//   -> 16 writes, last_addr=15, err_overflow=1; 17th word not accepted (in_ready=0).
//  T4: in_valid toggles 1,0,0,1,0,1
//   -> writes only on accepted cycles; addresses contiguous 0,1,2.
//  T5: reset_n low during 3rd word of LOAD
//   -> state IDLE, all outputs 0 asynchronously; new load restarts at addr 0.
//  T6: start held during WAIT_MF, then mf_done=1 -> IDLE, no new load.
//   Next start -> new load; err_overflow cleared.

Source files
------------

// File: rtl/mem_loader_if.sv
// Valid/ready word stream feeding the loader. The source drives valid/data/last
// and the loader drives ready.
interface mem_loader_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/mem_loader.sv
// Streams a block of words into the shared data memory at 0..n-1, records the last
// address for the max-finder, then hands off with mf_start and waits for mf_done.
module mem_loader #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    mem_loader_if.slave   s,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [AW-1:0] last_addr,
    output logic [AW:0]   word_count,
    output logic          mf_start,
    input  logic          mf_done,
    output logic          busy,
    output logic          err_overflow
);
    typedef enum logic [1:0] {IDLE, LOAD, HANDOFF, WAIT_MF} state_t;

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr;
    logic          accept;
    logic          at_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        s.in_ready = 1'b0;
        accept     = 1'b0;
        at_end     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mf_start   = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                s.in_ready = 1'b1;
                accept     = s.in_valid;
                at_end     = (wr_ptr == LAST_PTR);
                if (accept) begin
                    mem_we    = 1'b1;
                    mem_addr  = wr_ptr;
                    mem_wdata = s.in_data;
                    // The memory is full at DEPTH-1, so hand off even without in_last.
                    if (s.in_last || at_end) state_nxt = HANDOFF;
                end
            end
            HANDOFF: begin
                mf_start  = 1'b1;
                state_nxt = WAIT_MF;
            end
            WAIT_MF: if (mf_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            last_addr    <= '0;
            word_count   <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                wr_ptr       <= '0;
                word_count   <= '0;
                err_overflow <= 1'b0;
            end
            if (accept) begin
                wr_ptr     <= wr_ptr + AW'(1);
                word_count <= word_count + (AW+1)'(1);
                if (s.in_last || at_end) last_addr <= wr_ptr;
                if (at_end && !s.in_last) err_overflow <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_mem_loader.sv
// Testbench for mem_loader: scoreboard of expected memory writes plus per-scenario checks.
module tb_mem_loader;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] last_addr;
    logic [AW:0]   word_count;
    logic          mf_start;
    logic          mf_done;
    logic          busy;
    logic          err_overflow;

    mem_loader_if #(.DW(DW)) bus ();

    mem_loader #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .s(bus.slave),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .last_addr(last_addr), .word_count(word_count), .mf_start(mf_start),
        .mf_done(mf_done), .busy(busy), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    wr_t sb[$];
    logic [DW-1:0] mem_model [DEPTH];

    // Write monitor: every write must match the next scoreboard entry.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && mem_we === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr=%0d data=%0h with empty scoreboard", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL write_match got addr=%0d data=%0h expected addr=%0d data=%0h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
            mem_model[mem_addr] = mem_wdata;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
    endtask

    task automatic expect_wr(input int a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = AW'(a);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_block();
        drive(1'b0, '0, 1'b0);
        tick();
        mf_done = 1'b1;
        tick();
        mf_done = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if ({busy, bus.in_ready, mem_we, mf_start, err_overflow} !== 5'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || last_addr !== '0 || word_count !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b rdy=%b we=%b mfs=%b err=%b last=%0d cnt=%0d expected all 0",
                     busy, bus.in_ready, mem_we, mf_start, err_overflow, last_addr, word_count);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] w [5];
        w = '{8'd3, 8'd9, 8'd1, 8'd7, 8'd2};
        do_start();
        @(negedge clk);
        n_chk++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_load_ready got rdy=%b busy=%b expected 1 1", bus.in_ready, busy);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, w[i], i == 4);
            expect_wr(i, w[i]);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        n_chk++;
        if (mf_start !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_mf_start got mfs=%b rdy=%b expected 1 0", mf_start, bus.in_ready);
        end
        n_chk++;
        if (last_addr !== 4'd4 || word_count !== 5'd5) begin
            n_fail++;
            $display("FAIL basic_counts got last=%0d cnt=%0d expected 4 5", last_addr, word_count);
        end
        tick();
        @(negedge clk);
        n_chk++;
        if (mf_start !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_wait got mfs=%b busy=%b expected 0 1", mf_start, busy);
        end
        mf_done = 1'b1;
        tick();
        mf_done = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL basic_idle got busy=%b pending=%0d expected 0 0", busy, sb.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (mem_model[i] !== w[i]) begin
                n_fail++;
                $display("FAIL basic_mem[%0d] got %0h expected %0h", i, mem_model[i], w[i]);
            end
        end
        tick();
    endtask

    task automatic test_single();
        do_start();
        drive(1'b1, 8'hA5, 1'b1);
        expect_wr(0, 8'hA5);
        tick();
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        n_chk++;
        if (mf_start !== 1'b1 || last_addr !== '0 || word_count !== 5'd1 || err_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL single_word got mfs=%b last=%0d cnt=%0d err=%b expected 1 0 1 0",
                     mf_start, last_addr, word_count, err_overflow);
        end
        n_chk++;
        if (mem_model[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_mem got %0h expected a5", mem_model[0]);
        end
        finish_block();
    endtask

    // Overflow leaves the DUT in WAIT_MF, which the start-during-wait test picks up.
    task automatic test_overflow();
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, DW'(8'h40 + i), 1'b0);
            expect_wr(i, DW'(8'h40 + i));
            tick();
        end
        drive(1'b1, 8'hFF, 1'b0);
        @(negedge clk);
        n_chk++;
        if (bus.in_ready !== 1'b0 || mem_we !== 1'b0 || mf_start !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_17th got rdy=%b we=%b mfs=%b expected 0 0 1", bus.in_ready, mem_we, mf_start);
        end
        n_chk++;
        if (err_overflow !== 1'b1 || last_addr !== 4'd15 || word_count !== 5'd16) begin
            n_fail++;
            $display("FAIL overflow_state got err=%b last=%0d cnt=%0d expected 1 15 16",
                     err_overflow, last_addr, word_count);
        end
        tick();
        @(negedge clk);
        n_chk++;
        if (mem_we !== 1'b0 || bus.in_ready !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL overflow_wait got we=%b rdy=%b pending=%0d expected 0 0 0", mem_we, bus.in_ready, sb.size());
        end
        drive(1'b0, '0, 1'b0);
        tick();
    endtask

    task automatic test_start_in_wait();
        start = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_ignores_start got busy=%b rdy=%b expected 1 0", busy, bus.in_ready);
        end
        mf_done = 1'b1;
        tick();
        start   = 1'b0;
        mf_done = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_done_idle got busy=%b rdy=%b expected 0 0", busy, bus.in_ready);
        end
        tick();
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || err_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_sticky got busy=%b err=%b expected 0 1", busy, err_overflow);
        end
        tick();
        do_start();
        @(negedge clk);
        n_chk++;
        if (err_overflow !== 1'b0 || word_count !== '0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear got err=%b cnt=%0d rdy=%b expected 0 0 1", err_overflow, word_count, bus.in_ready);
        end
        tick();
        drive(1'b1, 8'h11, 1'b1);
        expect_wr(0, 8'h11);
        tick();
        finish_block();
    endtask

    task automatic test_valid_gaps();
        logic [5:0] vpat;
        int a;
        vpat = 6'b101001;
        a = 0;
        do_start();
        for (int i = 0; i < 6; i++) begin
            if (vpat[i]) begin
                drive(1'b1, DW'(8'h80 + i), i == 5);
                expect_wr(a, DW'(8'h80 + i));
                a++;
                tick();
            end else begin
                drive(1'b0, 8'hEE, 1'b0);
                @(negedge clk);
                n_chk++;
                if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
                    n_fail++;
                    $display("FAIL gap_quiet cyc=%0d got we=%b addr=%0d data=%0h expected 0 0 0",
                             i, mem_we, mem_addr, mem_wdata);
                end
                tick();
            end
        end
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        n_chk++;
        if (mf_start !== 1'b1 || last_addr !== 4'd2 || word_count !== 5'd3) begin
            n_fail++;
            $display("FAIL gap_result got mfs=%b last=%0d cnt=%0d expected 1 2 3", mf_start, last_addr, word_count);
        end
        finish_block();
    endtask

    task automatic test_reset_mid_load();
        do_start();
        drive(1'b1, 8'h21, 1'b0);
        expect_wr(0, 8'h21);
        tick();
        drive(1'b1, 8'h22, 1'b0);
        expect_wr(1, 8'h22);
        tick();
        drive(1'b1, 8'h23, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, bus.in_ready, mem_we, mf_start, err_overflow} !== 5'b0 ||
            mem_addr !== '0 || last_addr !== '0 || word_count !== '0) begin
            n_fail++;
            $display("FAIL async_abort got busy=%b rdy=%b we=%b mfs=%b last=%0d cnt=%0d expected all 0",
                     busy, bus.in_ready, mem_we, mf_start, last_addr, word_count);
        end
        drive(1'b0, '0, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        n_chk++;
        if (mf_start !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL abort_no_handoff got mfs=%b busy=%b pending=%0d expected 0 0 0", mf_start, busy, sb.size());
        end
        tick();
        do_start();
        drive(1'b1, 8'h55, 1'b1);
        expect_wr(0, 8'h55);
        tick();
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        n_chk++;
        if (mem_model[0] !== 8'h55 || last_addr !== '0 || word_count !== 5'd1 || mf_start !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_addr0 got mem0=%0h last=%0d cnt=%0d mfs=%b expected 55 0 1 1",
                     mem_model[0], last_addr, word_count, mf_start);
        end
        finish_block();
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        mf_done = 1'b0;
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
        test_reset();
        test_basic();
        test_single();
        test_overflow();
        test_start_in_wait();
        test_valid_gaps();
        test_reset_mid_load();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
